lc3_mem_ctrl: RTL and testbench

- Memory-side end of the LC-3 address path. MAR loads from the bus, driven by the MAR-select mux, the PC or the ALU.
- This block registers MAR and MDR, decodes the address, runs multi-cycle memory accesses over a valid/ready handshake and implements the memory-mapped keyboard/display registers.
- It returns R (o_ready) to the control FSM. It sits between the datapath bus and external memory/devices.

---
 rtl/lc3_pkg.sv | 21 ++
 rtl/lc3_io_regs.sv | 82 ++++++++
 rtl/lc3_mem_ctrl.sv | 129 ++++++++++++
 tb/tb_lc3_mem_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_pkg.sv
// Shared constants for the LC-3 memory controller: IO map, FSM states, R/W encoding.
package lc3_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned CHAR_W = 8;

  localparam logic [DATA_W-1:0] LC3_KBSR_ADDR = 16'hFE00;
  localparam logic [DATA_W-1:0] LC3_KBDR_ADDR = 16'hFE02;
  localparam logic [DATA_W-1:0] LC3_DSR_ADDR  = 16'hFE04;
  localparam logic [DATA_W-1:0] LC3_DDR_ADDR  = 16'hFE06;
  localparam logic [DATA_W-1:0] LC3_IO_BASE   = 16'hFE00;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MEM  = 2'd1;
  localparam logic [1:0] ST_IO   = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/lc3_io_regs.sv
// Memory-mapped keyboard/display registers with read mux and device handshakes.
module lc3_io_regs
  import lc3_pkg::*;
#(
  parameter logic [DATA_W-1:0] KBSR_ADDR = LC3_KBSR_ADDR,
  parameter logic [DATA_W-1:0] KBDR_ADDR = LC3_KBDR_ADDR,
  parameter logic [DATA_W-1:0] DSR_ADDR  = LC3_DSR_ADDR,
  parameter logic [DATA_W-1:0] DDR_ADDR  = LC3_DDR_ADDR
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_addr,
  input  logic              i_rd,
  input  logic              i_wr,
  input  logic              i_wdata_ie,
  input  logic [CHAR_W-1:0] i_wdata_char,
  output logic [DATA_W-1:0] o_rdata_c,
  input  logic              i_kb_valid,
  input  logic [CHAR_W-1:0] i_kb_data,
  output logic              o_disp_valid,
  output logic [CHAR_W-1:0] o_disp_data,
  input  logic              i_disp_ack
);

  logic              r_kb_rdy;
  logic              r_kb_ie;
  logic [CHAR_W-1:0] r_kbdr;
  logic              r_dsr_rdy;
  logic              r_disp_valid;
  logic [CHAR_W-1:0] r_disp_data;
  logic              w_kbdr_rd;
  logic              w_kbsr_wr;
  logic              w_ddr_wr;

  assign w_kbdr_rd    = i_rd && (i_addr == KBDR_ADDR);
  assign w_kbsr_wr    = i_wr && (i_addr == KBSR_ADDR);
  assign w_ddr_wr     = i_wr && (i_addr == DDR_ADDR);
  assign o_disp_valid = r_disp_valid;
  assign o_disp_data  = r_disp_data;

  // Read mux; unmapped IO addresses read as zero.
  always_comb begin
    o_rdata_c = '0;
    if (i_addr == KBSR_ADDR)      o_rdata_c = {r_kb_rdy, r_kb_ie, 14'b0};
    else if (i_addr == KBDR_ADDR) o_rdata_c = {8'b0, r_kbdr};
    else if (i_addr == DSR_ADDR)  o_rdata_c = {r_dsr_rdy, 15'b0};
  end

  // Keyboard: a new character beats a concurrent KBDR read-clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_kb_rdy <= 1'b0;
      r_kb_ie  <= 1'b0;
      r_kbdr   <= '0;
    end else begin
      if (i_kb_valid) begin
        r_kbdr   <= i_kb_data;
        r_kb_rdy <= 1'b1;
      end else if (w_kbdr_rd) begin
        r_kb_rdy <= 1'b0;
      end
      if (w_kbsr_wr) r_kb_ie <= i_wdata_ie;
    end
  end

  // Display: a DDR write beats a concurrent acknowledge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dsr_rdy    <= 1'b1;
      r_disp_valid <= 1'b0;
      r_disp_data  <= '0;
    end else if (w_ddr_wr) begin
      r_disp_data  <= i_wdata_char;
      r_disp_valid <= 1'b1;
      r_dsr_rdy    <= 1'b0;
    end else if (i_disp_ack && r_disp_valid) begin
      r_disp_valid <= 1'b0;
      r_dsr_rdy    <= 1'b1;
    end
  end

endmodule

// File: rtl/lc3_mem_ctrl.sv
// LC-3 MAR/MDR, address decode and multi-cycle memory/IO access sequencer.
module lc3_mem_ctrl
  import lc3_pkg::*;
#(
  parameter logic [DATA_W-1:0] KBSR_ADDR = LC3_KBSR_ADDR,
  parameter logic [DATA_W-1:0] KBDR_ADDR = LC3_KBDR_ADDR,
  parameter logic [DATA_W-1:0] DSR_ADDR  = LC3_DSR_ADDR,
  parameter logic [DATA_W-1:0] DDR_ADDR  = LC3_DDR_ADDR,
  parameter logic [DATA_W-1:0] IO_BASE   = LC3_IO_BASE
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_bus,
  input  logic              i_ld_mar,
  input  logic              i_ld_mdr,
  input  logic              i_mio_en,
  input  logic              i_rw,
  output logic [DATA_W-1:0] o_mar,
  output logic [DATA_W-1:0] o_mdr,
  output logic              o_ready,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [DATA_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  input  logic              i_mem_ready,
  input  logic              i_kb_valid,
  input  logic [CHAR_W-1:0] i_kb_data,
  output logic              o_disp_valid,
  output logic [CHAR_W-1:0] o_disp_data,
  input  logic              i_disp_ack
);

  logic [1:0]        r_state;
  logic [1:0]        w_next;
  logic [DATA_W-1:0] r_mar;
  logic [DATA_W-1:0] r_mdr;
  logic [DATA_W-1:0] r_rdbuf;
  logic              r_rw;
  logic              r_ready;
  logic              r_mem_en;
  logic              r_mem_we;
  logic              w_io_rd;
  logic              w_io_wr;
  logic              w_mar_open;
  logic [DATA_W-1:0] w_io_rdata;

  assign o_mar       = r_mar;
  assign o_mdr       = r_mdr;
  assign o_ready     = r_ready;
  assign o_mem_en    = r_mem_en;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mar;
  assign o_mem_wdata = r_mdr;

  assign w_io_rd    = (r_state == ST_IO) && (r_rw == RW_READ);
  assign w_io_wr    = (r_state == ST_IO) && (r_rw == RW_WRITE);
  // MAR is frozen from access entry until the access has been released.
  assign w_mar_open = !i_mio_en && ((r_state == ST_IDLE) || (r_state == ST_DONE));

  // Next-state: decode MAR on entry, wait for memory, hold DONE until release.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (i_mio_en) w_next = (r_mar < IO_BASE) ? ST_MEM : ST_IO;
      ST_MEM:  if (i_mem_ready) w_next = ST_DONE;
      ST_IO:   w_next = ST_DONE;
      ST_DONE: if (!i_mio_en) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // State register plus registered handshake outputs derived from next state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= ST_IDLE;
      r_rw     <= RW_READ;
      r_ready  <= 1'b0;
      r_mem_en <= 1'b0;
      r_mem_we <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_ready  <= (w_next == ST_DONE);
      r_mem_en <= (w_next == ST_MEM);
      r_mem_we <= (w_next == ST_MEM) && ((r_state == ST_IDLE) ? i_rw : r_rw);
      if ((r_state == ST_IDLE) && i_mio_en) r_rw <= i_rw;
    end
  end

  // MAR/MDR loads and the read buffer filled by memory or the IO read mux.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mar   <= '0;
      r_mdr   <= '0;
      r_rdbuf <= '0;
    end else begin
      if (i_ld_mar && w_mar_open) r_mar <= i_bus;
      if (i_ld_mdr && !i_mio_en) begin
        r_mdr <= i_bus;
      end else if (i_ld_mdr && (r_state == ST_DONE) && (r_rw == RW_READ)) begin
        r_mdr <= r_rdbuf;
      end
      if ((r_state == ST_MEM) && i_mem_ready) r_rdbuf <= i_mem_rdata;
      else if (w_io_rd)                       r_rdbuf <= w_io_rdata;
    end
  end

  lc3_io_regs #(
    .KBSR_ADDR (KBSR_ADDR),
    .KBDR_ADDR (KBDR_ADDR),
    .DSR_ADDR  (DSR_ADDR),
    .DDR_ADDR  (DDR_ADDR)
  ) u_io_regs (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_addr       (r_mar),
    .i_rd         (w_io_rd),
    .i_wr         (w_io_wr),
    .i_wdata_ie   (r_mdr[14]),
    .i_wdata_char (r_mdr[CHAR_W-1:0]),
    .o_rdata_c    (w_io_rdata),
    .i_kb_valid   (i_kb_valid),
    .i_kb_data    (i_kb_data),
    .o_disp_valid (o_disp_valid),
    .o_disp_data  (o_disp_data),
    .i_disp_ack   (i_disp_ack)
  );

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Bench for lc3_mem_ctrl: directed vector table, reset corner case, random ops vs model.
`timescale 1ns/1ps
module tb_lc3_mem_ctrl;

  logic        clk = 1'b0;
  logic        i_rst_n;
  logic [15:0] i_bus;
  logic        i_ld_mar, i_ld_mdr, i_mio_en, i_rw;
  logic [15:0] o_mar, o_mdr, o_mem_addr, o_mem_wdata, i_mem_rdata;
  logic        o_ready, o_mem_en, o_mem_we, i_mem_ready;
  logic        i_kb_valid, o_disp_valid, i_disp_ack;
  logic [7:0]  i_kb_data, o_disp_data;

  always #5 clk = ~clk;

  lc3_mem_ctrl dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_bus(i_bus), .i_ld_mar(i_ld_mar),
    .i_ld_mdr(i_ld_mdr), .i_mio_en(i_mio_en), .i_rw(i_rw), .o_mar(o_mar),
    .o_mdr(o_mdr), .o_ready(o_ready), .o_mem_en(o_mem_en), .o_mem_we(o_mem_we),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata),
    .i_mem_ready(i_mem_ready), .i_kb_valid(i_kb_valid), .i_kb_data(i_kb_data),
    .o_disp_valid(o_disp_valid), .o_disp_data(o_disp_data), .i_disp_ack(i_disp_ack)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state, expressed as the programmer-visible register contents.
  logic       m_kb_rdy, m_ie, m_busy;
  logic [7:0] m_kb_char, m_disp_char;
  logic [15:0] m_mem [logic [15:0]];

  typedef struct {
    logic [1:0]  pre;      // 0 none, 1 keyboard strobe, 2 display ack
    logic [7:0]  pre_ch;
    logic        rw;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          lat;
    logic [15:0] rdata;
    logic        kb_hit;
    logic [7:0]  kb_ch;
    logic        ack_hit;
    logic [15:0] exp_mdr;
    logic        exp_dv;
    logic [7:0]  exp_dd;
  } vec_t;

  vec_t vt [24];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset;
    m_kb_rdy = 1'b0; m_ie = 1'b0; m_busy = 1'b0;
    m_kb_char = 8'h00; m_disp_char = 8'h00;
  endtask

  function automatic logic [15:0] m_io_read(input logic [15:0] a);
    if (a == 16'hFE00) return {m_kb_rdy, m_ie, 14'b0};
    if (a == 16'hFE02) return {8'h00, m_kb_char};
    if (a == 16'hFE04) return {~m_busy, 15'b0};
    return 16'h0000;
  endfunction

  task automatic kb_strobe(input logic [7:0] ch);
    i_kb_valid = 1'b1; i_kb_data = ch; tick; i_kb_valid = 1'b0;
  endtask

  task automatic disp_ack;
    i_disp_ack = 1'b1; tick; i_disp_ack = 1'b0;
  endtask

  // One full access as the control FSM would issue it; the bench plays the memory.
  task automatic run_access(input logic rw, input logic [15:0] addr, input logic [15:0] wdata,
                            input int lat, input logic [15:0] rdata, input logic kb_hit,
                            input logic [7:0] kb_ch, input logic ack_hit, input int hold,
                            input logic noise, output logic [15:0] got_mdr);
    int   ticks, mem_cycles;
    logic is_mem;
    is_mem = (addr < 16'hFE00);
    i_bus = addr;  i_ld_mar = 1'b1; tick; i_ld_mar = 1'b0;
    i_bus = wdata; i_ld_mdr = 1'b1; tick; i_ld_mdr = 1'b0;
    i_rw = rw; i_mio_en = 1'b1;
    ticks = 0; mem_cycles = 0;
    while (ticks < 40) begin
      tick; ticks++;
      i_kb_valid = 1'b0; i_disp_ack = 1'b0; i_mem_ready = 1'b0;
      if (o_ready) break;
      if (noise) begin
        i_ld_mar = 1'($urandom_range(0, 1)); i_bus = 16'($urandom); i_rw = 1'($urandom_range(0, 1));
      end
      if (o_mem_en) begin
        mem_cycles++;
        check("mem_addr", o_mem_addr, addr);
        check("mem_we", 16'(o_mem_we), 16'(rw));
        check("mem_wdata", o_mem_wdata, wdata);
        if (mem_cycles == lat) begin
          i_mem_ready = 1'b1;
          i_mem_rdata = rw ? 16'($urandom) : rdata;
        end
      end else if (!is_mem && ticks == 1) begin
        i_kb_valid = kb_hit; i_kb_data = kb_ch; i_disp_ack = ack_hit;
      end
    end
    i_ld_mar = 1'b0; i_rw = rw;
    check("latency", 16'(ticks), is_mem ? 16'(lat + 1) : 16'd2);
    check("mem_cycles", 16'(mem_cycles), is_mem ? 16'(lat) : 16'd0);
    for (int h = 0; h < hold; h++) begin
      tick;
      check("ready_hold", 16'(o_ready), 16'd1);
    end
    if (rw == 1'b0) begin
      i_ld_mdr = 1'b1; tick; i_ld_mdr = 1'b0;
      check("ready_ld", 16'(o_ready), 16'd1);
    end
    i_mio_en = 1'b0; tick;
    check("ready_drop", 16'(o_ready), 16'd0);
    check("mar_kept", o_mar, addr);
    got_mdr = o_mdr;
  endtask

  task automatic check_reset_outputs;
    check("rst_ready", 16'(o_ready), 16'd0);
    check("rst_mem_en", 16'(o_mem_en), 16'd0);
    check("rst_mem_we", 16'(o_mem_we), 16'd0);
    check("rst_mar", o_mar, 16'h0000);
    check("rst_mdr", o_mdr, 16'h0000);
    check("rst_mem_addr", o_mem_addr, 16'h0000);
    check("rst_disp_valid", 16'(o_disp_valid), 16'd0);
    check("rst_disp_data", 16'(o_disp_data), 16'h0000);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] got, exp, addr, wdata, rdata;
    logic        rw, kb_hit, ack_hit, busy_before;
    logic [7:0]  kb_ch;
    int          op, lat;

    vt[0]  = '{2'd1, 8'h41, 1'b0, 16'hFE00, 16'h0000, 0, 16'h0000, 1'b0, 8'h00, 1'b0, 16'h8000, 1'b0, 8'h00};
    vt[1]  = '{2'd0, 8'h00, 1'b0, 16'hFE02, 16'h0000, 0, 16'h0000, 1'b0, 8'h00, 1'b0, 16'h0041, 1'b0, 8'h00};
    vt[2]  = '{2'd0, 8'h00, 1'b0, 16'hFE00, 16'h0000, 0, 16'h0000, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 8'h00};
    vt[3]  = '{2'd0, 8'h00, 1'b1, 16'hFE06, 16'h0058, 0, 16'h0000, 1'b0, 8'h00, 1'b0, 16'h0058, 1'b1, 8'h58};
    vt[4]  = '{2'd0, 8'h00, 1'b0, 16'hFE04, 16'h0000, 0, 16'h0000, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b1, 8'h58};
    vt[5]  = '{2'd2, 8'h00, 1'b0, 16'hFE04, 16'h0000, 0, 16'h0000, 1'b0, 8'h00, 1'b0, 16'h8000, 1'b0, 8'h58};
    vt[6]  = '{2'd0, 8'h00, 1'b1, 16'h3000, 16'hBEEF, 3, 16'h0000, 1'b0, 8'h00, 1'b0, 16'hBEEF, 1'b0, 8'h58};
    vt[7]  = '{2'd0, 8'h00, 1'b0, 16'h3000, 16'h0000, 1, 16'h1234, 1'b0, 8'h00, 1'b0, 16'h1234, 1'b0, 8'h58};
    vt[8]  = '{2'd1, 8'h41, 1'b0, 16'hFE02, 16'h0000, 0, 16'h0000, 1'b1, 8'h42, 1'b0, 16'h0041, 1'b0, 8'h58};
    vt[9]  = '{2'd0, 8'h00, 1'b0, 16'hFE00, 16'h0000, 0, 16'h0000, 1'b0, 8'h00, 1'b0, 16'h8000, 1'b0, 8'h58};
    vt[10] = '{2'd0, 8'h00, 1'b0, 16'hFE02, 16'h0000, 0, 16'h0000, 1'b0, 8'h00, 1'b0, 16'h0042, 1'b0, 8'h58};
    vt[11] = '{2'd0, 8'h00, 1'b0, 16'hFE00, 16'h0000, 0, 16'h0000, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 8'h58};
    vt[12] = '{2'd0, 8'h00, 1'b1, 16'hFE00, 16'h4000, 0, 16'h0000, 1'b0, 8'h00, 1'b0, 16'h4000, 1'b0, 8'h58};
    vt[13] = '{2'd0, 8'h00, 1'b0, 16'hFE00, 16'h0000, 0, 16'h0000, 1'b0, 8'h00, 1'b0, 16'h4000, 1'b0, 8'h58};
    vt[14] = '{2'd0, 8'h00, 1'b0, 16'hFE08, 16'h0000, 0, 16'h0000, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 8'h58};
    vt[15] = '{2'd0, 8'h00, 1'b1, 16'hFE06, 16'h0059, 0, 16'h0000, 1'b0, 8'h00, 1'b0, 16'h0059, 1'b1, 8'h59};
    vt[16] = '{2'd0, 8'h00, 1'b1, 16'hFE06, 16'h005A, 0, 16'h0000, 1'b0, 8'h00, 1'b0, 16'h005A, 1'b1, 8'h5A};
    vt[17] = '{2'd0, 8'h00, 1'b1, 16'hFE06, 16'h0061, 0, 16'h0000, 1'b0, 8'h00, 1'b1, 16'h0061, 1'b1, 8'h61};
    vt[18] = '{2'd0, 8'h00, 1'b0, 16'hFE04, 16'h0000, 0, 16'h0000, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b1, 8'h61};
    vt[19] = '{2'd0, 8'h00, 1'b0, 16'hFDFF, 16'h0000, 2, 16'hCAFE, 1'b0, 8'h00, 1'b0, 16'hCAFE, 1'b1, 8'h61};
    vt[20] = '{2'd0, 8'h00, 1'b1, 16'hFFFF, 16'h1234, 0, 16'h0000, 1'b0, 8'h00, 1'b0, 16'h1234, 1'b1, 8'h61};
    vt[21] = '{2'd0, 8'h00, 1'b0, 16'hFE06, 16'h0000, 0, 16'h0000, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b1, 8'h61};
    vt[22] = '{2'd0, 8'h00, 1'b1, 16'hFE00, 16'hBFFF, 0, 16'h0000, 1'b0, 8'h00, 1'b0, 16'hBFFF, 1'b1, 8'h61};
    vt[23] = '{2'd0, 8'h00, 1'b0, 16'hFE00, 16'h0000, 0, 16'h0000, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b1, 8'h61};

    i_rst_n = 1'b0; i_bus = '0; i_ld_mar = 0; i_ld_mdr = 0; i_mio_en = 0; i_rw = 0;
    i_mem_rdata = '0; i_mem_ready = 0; i_kb_valid = 0; i_kb_data = '0; i_disp_ack = 0;
    tick; tick;
    check_reset_outputs();
    i_rst_n = 1'b1;
    tick;

    // Directed vectors
    for (int i = 0; i < 24; i++) begin
      if (vt[i].pre == 2'd1) kb_strobe(vt[i].pre_ch);
      else if (vt[i].pre == 2'd2) disp_ack();
      run_access(vt[i].rw, vt[i].addr, vt[i].wdata, vt[i].lat, vt[i].rdata, vt[i].kb_hit,
                 vt[i].kb_ch, vt[i].ack_hit, i % 3, 1'(i % 2), got);
      check($sformatf("vec%0d_mdr", i), got, vt[i].exp_mdr);
      check($sformatf("vec%0d_dv", i), 16'(o_disp_valid), 16'(vt[i].exp_dv));
      check($sformatf("vec%0d_dd", i), 16'(o_disp_data), 16'(vt[i].exp_dd));
    end

    // Reset in the middle of a memory write that memory never acknowledges.
    i_bus = 16'h3000; i_ld_mar = 1'b1; tick; i_ld_mar = 1'b0;
    i_bus = 16'hBEEF; i_ld_mdr = 1'b1; tick; i_ld_mdr = 1'b0;
    i_rw = 1'b1; i_mio_en = 1'b1;
    tick; tick;
    check("midmem_en", 16'(o_mem_en), 16'd1);
    #1 i_rst_n = 1'b0;
    #1 check_reset_outputs();
    i_mio_en = 1'b0; i_rw = 1'b0;
    tick;
    i_rst_n = 1'b1;
    tick;
    check("post_rst_ready", 16'(o_ready), 16'd0);
    model_reset();
    run_access(1'b0, 16'hFE04, 16'h0000, 0, 16'h0000, 1'b0, 8'h00, 1'b0, 0, 1'b0, got);
    check("post_rst_dsr", got, 16'h8000);

    // Random operations against the register-level model
    for (int it = 0; it < 80; it++) begin
      op = $urandom_range(0, 5);
      if (op == 0) begin
        kb_ch = 8'($urandom);
        kb_strobe(kb_ch);
        m_kb_rdy = 1'b1; m_kb_char = kb_ch;
      end else if (op == 1) begin
        disp_ack();
        m_busy = 1'b0;
      end else begin
        rw = 1'($urandom_range(0, 1));
        wdata = 16'($urandom);
        kb_hit = 1'b0; ack_hit = 1'b0; kb_ch = 8'($urandom); lat = 0; rdata = '0;
        if (op < 4) begin
          case ($urandom_range(0, 3))
            0:       addr = 16'hFDFF;
            1:       addr = 16'h0000;
            default: addr = 16'h3000 + 16'($urandom_range(0, 7));
          endcase
          lat = $urandom_range(1, 4);
          if (!rw) begin
            if (!m_mem.exists(addr)) m_mem[addr] = 16'($urandom);
            rdata = m_mem[addr];
          end
        end else begin
          addr = ($urandom_range(0, 5) == 5) ? 16'hFFFE : 16'hFE00 + 16'(2 * $urandom_range(0, 4));
          kb_hit = ($urandom_range(0, 3) == 0);
          ack_hit = ($urandom_range(0, 3) == 0);
        end
        run_access(rw, addr, wdata, lat, rdata, kb_hit, kb_ch, ack_hit,
                   $urandom_range(0, 2), 1'b1, got);
        if (addr < 16'hFE00) begin
          exp = rw ? wdata : rdata;
          if (rw) m_mem[addr] = wdata;
        end else begin
          busy_before = m_busy;
          exp = rw ? wdata : m_io_read(addr);
          if (!rw && addr == 16'hFE02) m_kb_rdy = 1'b0;
          if (rw && addr == 16'hFE00) m_ie = wdata[14];
          if (rw && addr == 16'hFE06) begin
            m_busy = 1'b1; m_disp_char = wdata[7:0];
          end else if (ack_hit && busy_before) begin
            m_busy = 1'b0;
          end
          if (kb_hit) begin
            m_kb_rdy = 1'b1; m_kb_char = kb_ch;
          end
        end
        check($sformatf("rnd%0d_mdr", it), got, exp);
      end
      check($sformatf("rnd%0d_dv", it), 16'(o_disp_valid), 16'(m_busy));
      check($sformatf("rnd%0d_dd", it), 16'(o_disp_data), 16'(m_disp_char));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
